// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32 pipeline: CSR read port, write commit, trap/MRET state, interrupt detect.
// Optional feature macro: CSR_COUNTERS_EN (adds 64-bit mcycle/minstret counters).
module csr_file #(
    parameter logic [31:0] TRAP_VECTOR_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID           = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] readAddress,
    output logic [31:0] readData,
    output logic        readIllegal,
    input  logic        writeEnable,
    input  logic [11:0] writeAddress,
    input  logic [31:0] writeData,
    input  logic        retire,
    input  logic        trapValid,
    input  logic [31:0] trapCause,
    input  logic [31:0] trapPC,
    input  logic [31:0] trapValue,
    input  logic        mretValid,
    input  logic        softwareIrq,
    input  logic        timerIrq,
    input  logic        externalIrq,
    output logic [31:0] trapVector,
    output logic [31:0] mretTarget,
    output logic        interruptPending,
    output logic [31:0] interruptCause
);
    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
    localparam logic [31:0] MISA_VALUE     = 32'h4000_0100;

    logic        mstatusMie;
    logic        mstatusMpie;
    logic        mieMsie;
    logic        mieMtie;
    logic        mieMeie;
    logic [29:0] mtvecBase;
    logic [31:0] mscratch;
    logic [29:0] mepcBase;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic        csrWrite;
    logic [31:0] mstatusValue;
    logic [31:0] mieValue;
    logic [31:0] mipValue;
    logic        unusedPcBits;

    // Traps and MRET pre-empt a same-cycle software write entirely
    assign csrWrite     = writeEnable & ~trapValid & ~mretValid;
    assign mstatusValue = {19'd0, 2'b11, 3'd0, mstatusMpie, 3'd0, mstatusMie, 3'd0};
    assign mieValue     = {20'd0, mieMeie, 3'd0, mieMtie, 3'd0, mieMsie, 3'd0};
    assign mipValue     = {20'd0, externalIrq, 3'd0, timerIrq, 3'd0, softwareIrq, 3'd0};
    assign trapVector   = {mtvecBase, 2'b00};
    assign mretTarget   = {mepcBase, 2'b00};
    assign unusedPcBits = ^trapPC[1:0];

    // Architectural CSR state: reset, then trap > MRET > software write
    always_ff @(posedge clock) begin
        if (reset) begin
            mstatusMie  <= 1'b0;
            mstatusMpie <= 1'b0;
            mieMsie     <= 1'b0;
            mieMtie     <= 1'b0;
            mieMeie     <= 1'b0;
            mtvecBase   <= TRAP_VECTOR_RESET[31:2];
            mscratch    <= 32'd0;
            mepcBase    <= 30'd0;
            mcause      <= 32'd0;
            mtval       <= 32'd0;
        end else if (trapValid) begin
            mepcBase    <= trapPC[31:2];
            mcause      <= trapCause;
            mtval       <= trapValue;
            mstatusMpie <= mstatusMie;
            mstatusMie  <= 1'b0;
        end else if (mretValid) begin
            mstatusMie  <= mstatusMpie;
            mstatusMpie <= 1'b1;
        end else if (csrWrite) begin
            case (writeAddress)
                ADDR_MSTATUS: begin
                    mstatusMie  <= writeData[3];
                    mstatusMpie <= writeData[7];
                end
                ADDR_MIE: begin
                    mieMsie <= writeData[3];
                    mieMtie <= writeData[7];
                    mieMeie <= writeData[11];
                end
                ADDR_MTVEC:    mtvecBase <= writeData[31:2];
                ADDR_MSCRATCH: mscratch  <= writeData;
                ADDR_MEPC:     mepcBase  <= writeData[31:2];
                ADDR_MCAUSE:   mcause    <= writeData;
                ADDR_MTVAL:    mtval     <= writeData;
                default:       mscratch  <= mscratch;
            endcase
        end else begin
            mscratch <= mscratch;
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;

    // Free-running cycle counter; a write to either half replaces that cycle's increment
    always_ff @(posedge clock) begin
        if (reset) begin
            mcycle <= 64'd0;
        end else if (csrWrite && (writeAddress == ADDR_MCYCLE)) begin
            mcycle <= {mcycle[63:32], writeData};
        end else if (csrWrite && (writeAddress == ADDR_MCYCLEH)) begin
            mcycle <= {writeData, mcycle[31:0]};
        end else begin
            mcycle <= mcycle + 64'd1;
        end
    end

    // Retired-instruction counter with the same write-over-increment rule
    always_ff @(posedge clock) begin
        if (reset) begin
            minstret <= 64'd0;
        end else if (csrWrite && (writeAddress == ADDR_MINSTRET)) begin
            minstret <= {minstret[63:32], writeData};
        end else if (csrWrite && (writeAddress == ADDR_MINSTRETH)) begin
            minstret <= {writeData, minstret[31:0]};
        end else if (retire) begin
            minstret <= minstret + 64'd1;
        end else begin
            minstret <= minstret;
        end
    end
`else
    logic unusedRetire;
    assign unusedRetire = retire;
`endif

    // Combinational read mux; unimplemented addresses flag readIllegal
    always_comb begin
        readData    = 32'd0;
        readIllegal = 1'b0;
        case (readAddress)
            ADDR_MSTATUS:   readData = mstatusValue;
            ADDR_MISA:      readData = MISA_VALUE;
            ADDR_MIE:       readData = mieValue;
            ADDR_MTVEC:     readData = {mtvecBase, 2'b00};
            ADDR_MSCRATCH:  readData = mscratch;
            ADDR_MEPC:      readData = {mepcBase, 2'b00};
            ADDR_MCAUSE:    readData = mcause;
            ADDR_MTVAL:     readData = mtval;
            ADDR_MIP:       readData = mipValue;
            ADDR_MHARTID:   readData = HART_ID;
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE:    readData = mcycle[31:0];
            ADDR_MINSTRET:  readData = minstret[31:0];
            ADDR_MCYCLEH:   readData = mcycle[63:32];
            ADDR_MINSTRETH: readData = minstret[63:32];
`else
            ADDR_MCYCLE, ADDR_MINSTRET, ADDR_MCYCLEH, ADDR_MINSTRETH: readData = 32'd0;
`endif
            default: begin
                readData    = 32'd0;
                readIllegal = 1'b1;
            end
        endcase
    end

    // Interrupt detect: external > software > timer
    always_comb begin
        interruptPending = mstatusMie & ((externalIrq & mieMeie) | (softwareIrq & mieMsie) | (timerIrq & mieMtie));
        if (externalIrq && mieMeie) begin
            interruptCause = 32'h8000_000B;
        end else if (softwareIrq && mieMsie) begin
            interruptCause = 32'h8000_0003;
        end else if (timerIrq && mieMtie) begin
            interruptCause = 32'h8000_0007;
        end else begin
            interruptCause = 32'd0;
        end
    end
endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file: vector table plus trap/MRET/counter sequences.
module tb_csr_file;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] readAddress = 12'd0;
    logic [31:0] readData;
    logic        readIllegal;
    logic        writeEnable = 1'b0;
    logic [11:0] writeAddress = 12'd0;
    logic [31:0] writeData = 32'd0;
    logic        retire = 1'b0;
    logic        trapValid = 1'b0;
    logic [31:0] trapCause = 32'd0;
    logic [31:0] trapPC = 32'd0;
    logic [31:0] trapValue = 32'd0;
    logic        mretValid = 1'b0;
    logic        softwareIrq = 1'b0;
    logic        timerIrq = 1'b0;
    logic        externalIrq = 1'b0;
    logic [31:0] trapVector;
    logic [31:0] mretTarget;
    logic        interruptPending;
    logic [31:0] interruptCause;

    int compared = 0;
    int mismatched = 0;

    csr_file #(.TRAP_VECTOR_RESET(32'h0000_0000), .HART_ID(32'h0000_0000)) dut (
        .clock(clock), .reset(reset),
        .readAddress(readAddress), .readData(readData), .readIllegal(readIllegal),
        .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData),
        .retire(retire), .trapValid(trapValid), .trapCause(trapCause), .trapPC(trapPC),
        .trapValue(trapValue), .mretValid(mretValid),
        .softwareIrq(softwareIrq), .timerIrq(timerIrq), .externalIrq(externalIrq),
        .trapVector(trapVector), .mretTarget(mretTarget),
        .interruptPending(interruptPending), .interruptCause(interruptCause)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        we;
        logic [11:0] wa;
        logic [31:0] wd;
        logic [11:0] ra;
        logic [31:0] expData;
        logic        expIll;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic readChk(input string name, input logic [11:0] addr, input logic [31:0] expD, input logic expI);
        readAddress = addr;
        #1;
        check(name, readData, expD);
        check({name, ".illegal"}, {31'd0, readIllegal}, {31'd0, expI});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic doWrite(input logic [11:0] addr, input logic [31:0] data);
        writeEnable  = 1'b1;
        writeAddress = addr;
        writeData    = data;
        step();
        writeEnable  = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 12'h300, 32'h0,         12'h300, 32'h0000_1800, 1'b0};
        vecs[1]  = '{1'b0, 12'h300, 32'h0,         12'h305, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 12'h300, 32'h0,         12'h7C0, 32'h0000_0000, 1'b1};
        vecs[3]  = '{1'b1, 12'h305, 32'h8000_0103, 12'h305, 32'h8000_0100, 1'b0};
        vecs[4]  = '{1'b1, 12'h300, 32'hFFFF_FFFF, 12'h300, 32'h0000_1888, 1'b0};
        vecs[5]  = '{1'b1, 12'h340, 32'hDEAD_BEEF, 12'h340, 32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{1'b1, 12'h301, 32'h0000_1234, 12'h301, 32'h4000_0100, 1'b0};
        vecs[7]  = '{1'b1, 12'hF14, 32'h0000_0005, 12'hF14, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b1, 12'h7C0, 32'h0000_0001, 12'h7C0, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 12'h341, 32'h0000_0107, 12'h341, 32'h0000_0104, 1'b0};
        vecs[10] = '{1'b1, 12'h304, 32'hFFFF_FFFF, 12'h304, 32'h0000_0888, 1'b0};
        vecs[11] = '{1'b1, 12'h342, 32'h8000_000B, 12'h342, 32'h8000_000B, 1'b0};
        vecs[12] = '{1'b1, 12'h343, 32'h1357_9BDF, 12'h343, 32'h1357_9BDF, 1'b0};
        vecs[13] = '{1'b1, 12'h344, 32'hFFFF_FFFF, 12'h344, 32'h0000_0000, 1'b0};
        vecs[14] = '{1'b1, 12'h300, 32'h0000_0000, 12'h300, 32'h0000_1800, 1'b0};
        vecs[15] = '{1'b1, 12'h304, 32'h0000_0000, 12'h304, 32'h0000_0000, 1'b0};

        step();
        step();
        reset = 1'b0;
        #1;
        check("trapVector.reset", trapVector, 32'h0000_0000);
        check("pending.reset", {31'd0, interruptPending}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].we) doWrite(vecs[i].wa, vecs[i].wd);
            readChk($sformatf("vec%0d", i), vecs[i].ra, vecs[i].expData, vecs[i].expIll);
        end

        // Interrupt enable and priority
        doWrite(12'h300, 32'h0000_0008);
        doWrite(12'h304, 32'h0000_0080);
        timerIrq = 1'b1;
        #1;
        check("pending.timer", {31'd0, interruptPending}, 32'd1);
        check("cause.timer", interruptCause, 32'h8000_0007);
        readChk("mip.timer", 12'h344, 32'h0000_0080, 1'b0);
        doWrite(12'h304, 32'h0000_0888);
        softwareIrq = 1'b1;
        #1;
        check("cause.software", interruptCause, 32'h8000_0003);
        externalIrq = 1'b1;
        #1;
        check("cause.external", interruptCause, 32'h8000_000B);
        softwareIrq = 1'b0;
        externalIrq = 1'b0;
        #1;
        check("cause.timerAgain", interruptCause, 32'h8000_0007);

        // Trap wins over same-cycle mscratch write
        trapValid = 1'b1; trapPC = 32'h0000_0107; trapCause = 32'h8000_0007; trapValue = 32'h0000_0ABC;
        writeEnable = 1'b1; writeAddress = 12'h340; writeData = 32'h1111_1111;
        step();
        trapValid = 1'b0; writeEnable = 1'b0;
        readChk("trap.mepc", 12'h341, 32'h0000_0104, 1'b0);
        check("trap.mretTarget", mretTarget, 32'h0000_0104);
        readChk("trap.mcause", 12'h342, 32'h8000_0007, 1'b0);
        readChk("trap.mtval", 12'h343, 32'h0000_0ABC, 1'b0);
        readChk("trap.mstatus", 12'h300, 32'h0000_1880, 1'b0);
        check("trap.pending", {31'd0, interruptPending}, 32'd0);
        readChk("trap.mscratch", 12'h340, 32'hDEAD_BEEF, 1'b0);

        // MRET wins over same-cycle mstatus write
        mretValid = 1'b1;
        writeEnable = 1'b1; writeAddress = 12'h300; writeData = 32'h0000_0000;
        step();
        mretValid = 1'b0; writeEnable = 1'b0;
        readChk("mret.mstatus", 12'h300, 32'h0000_1888, 1'b0);
        check("mret.pending", {31'd0, interruptPending}, 32'd1);

        // Trap and MRET together: trap wins
        trapValid = 1'b1; mretValid = 1'b1; trapPC = 32'h0000_0200;
        step();
        trapValid = 1'b0; mretValid = 1'b0;
        readChk("trapMret.mstatus", 12'h300, 32'h0000_1880, 1'b0);
        readChk("trapMret.mepc", 12'h341, 32'h0000_0200, 1'b0);
        timerIrq = 1'b0;

`ifdef CSR_COUNTERS_EN
        doWrite(12'hB00, 32'hFFFF_FFFF);
        readChk("mcycle.wrLow", 12'hB00, 32'hFFFF_FFFF, 1'b0);
        doWrite(12'hB80, 32'h0000_0000);
        readChk("mcycle.holdLow", 12'hB00, 32'hFFFF_FFFF, 1'b0);
        readChk("mcycleh.wr", 12'hB80, 32'h0000_0000, 1'b0);
        step();
        readChk("mcycleh.carry", 12'hB80, 32'h0000_0001, 1'b0);
        readChk("mcycle.carryLow", 12'hB00, 32'h0000_0000, 1'b0);
        doWrite(12'hB00, 32'hFFFF_FFFF);
        doWrite(12'hB80, 32'hFFFF_FFFF);
        step();
        readChk("mcycle.wrapLow", 12'hB00, 32'h0000_0000, 1'b0);
        readChk("mcycle.wrapHigh", 12'hB80, 32'h0000_0000, 1'b0);
        doWrite(12'hB02, 32'h0000_0000);
        doWrite(12'hB82, 32'h0000_0000);
        retire = 1'b1;
        for (int i = 0; i < 5; i++) step();
        retire = 1'b0;
        readChk("minstret.plus5", 12'hB02, 32'h0000_0005, 1'b0);
        retire = 1'b1;
        doWrite(12'hB02, 32'h0000_0100);
        retire = 1'b0;
        readChk("minstret.wrRetire", 12'hB02, 32'h0000_0100, 1'b0);
        readChk("minstreth.hold", 12'hB82, 32'h0000_0000, 1'b0);
`else
        retire = 1'b1;
        for (int i = 0; i < 100; i++) step();
        retire = 1'b0;
        readChk("noCnt.mcycle", 12'hB00, 32'h0000_0000, 1'b0);
        readChk("noCnt.minstret", 12'hB02, 32'h0000_0000, 1'b0);
        doWrite(12'hB80, 32'h1234_5678);
        readChk("noCnt.mcycleh", 12'hB80, 32'h0000_0000, 1'b0);
        readChk("noCnt.minstreth", 12'hB82, 32'h0000_0000, 1'b0);
`endif

        // Reset during a write discards it
        writeEnable = 1'b1; writeAddress = 12'h340; writeData = 32'h5555_5555;
        reset = 1'b1;
        step();
        writeEnable = 1'b0;
        reset = 1'b0;
        readChk("rst.mscratch", 12'h340, 32'h0000_0000, 1'b0);
        readChk("rst.mstatus", 12'h300, 32'h0000_1800, 1'b0);
        readChk("rst.mtvec", 12'h305, 32'h0000_0000, 1'b0);
        readChk("rst.mepc", 12'h341, 32'h0000_0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
